// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   Parameter N : operand/sum width in bits (1..32).
//   start       : request to latch a, b, cin (and sub) and begin an addition
//   a, b        : N-bit operands, sampled on the accepting edge
//   cin         : carry-in, sampled on the accepting edge
//   sub         : subtract select, present only when SERIAL_SUB_EN is defined
//   busy        : high while an addition is running
//   done        : one-cycle pulse when s/cout become valid
//   s, cout     : registered sum and carry-out, held until the next completion
// master drives requests (operand side); slave is the adder itself.
interface serial_adder_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;

  modport master (
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, s, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one operand bit per clock, LSB first.
// Two half-adder stages plus a carry flip-flop form the full adder; the result
// {cout, s} = a + b + cin is registered on completion.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset; aborts a running addition
//   io_bus : serial_adder_if.slave (start/a/b/cin[/sub] in, busy/done/s/cout out)
// Optional feature macro: SERIAL_SUB_EN adds the sub input; sub=1 computes
// a - b mod 2^N with cout=1 meaning no borrow (cin is ignored).
module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  serial_adder_if.slave  io_bus
);

  localparam int unsigned CW = $clog2(N) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sum;
  logic [N-1:0]  r_s;
  logic          r_cout;

  logic          w_sub;
  logic [N-1:0]  w_b_load;
  logic          w_c_load;
  logic          w_last;
  logic          w_h;
  logic          w_g;
  logic          w_s;
  logic          w_p;
  logic          w_c_next;
  logic [N-1:0]  w_sum_next;

`ifdef SERIAL_SUB_EN
  assign w_sub = io_bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
  assign w_b_load = w_sub ? ~io_bus.b : io_bus.b;
  assign w_c_load = w_sub ? 1'b1 : io_bus.cin;

  assign w_last = (r_cnt == CW'(N - 1));

  // Stage 1 half adder on the operand bits.
  assign w_h = r_a[0] ^ r_b[0];
  assign w_g = r_a[0] & r_b[0];
  // Stage 2 half adder folds in the stored carry.
  assign w_s = w_h ^ r_carry;
  assign w_p = w_h & r_carry;
  assign w_c_next = w_g | w_p;

  // New sum bit enters from the MSB side; works for N=1 as well.
  always_comb begin
    w_sum_next        = r_sum >> 1;
    w_sum_next[N-1]   = w_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (io_bus.start) begin
            r_a     <= io_bus.a;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c_next;
          r_sum   <= w_sum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_s     <= w_sum_next;
            r_cout  <= w_c_next;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.busy = (r_state == ST_RUN);
  assign io_bus.done = (r_state == ST_DONE);
  assign io_bus.s    = r_s;
  assign io_bus.cout = r_cout;

endmodule
